jpeg_block_scheduler: RTL and testbench

JPEG_BLOCK_SCHEDULER -- requirements
Module: jpeg_block_scheduler

---
 rtl/jpeg_block_scheduler_pkg.sv | 30 +++
 rtl/jpeg_block_scheduler_if.sv | 24 ++
 rtl/block_pack_buffer.sv | 37 +++
 rtl/jpeg_block_scheduler.sv | 164 ++++++++++++++++
 tb/tb_jpeg_block_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_block_scheduler_pkg.sv
// Shared definitions for the JPEG block scheduler.
// Holds the 4-bit FSM state encoding, the block geometry, the pixel field
// offsets inside a 32-bit pixel word, and the packed RGB storage type.
package jpeg_block_scheduler_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_FILL = 4'd1,
    ST_KICK = 4'd2,
    ST_WAIT = 4'd3,
    ST_EMIT = 4'd4,
    ST_DONE = 4'd5
  } state_e;

  localparam int BLOCK_PIXELS = 64;
  localparam int IDX_W        = $clog2(BLOCK_PIXELS);
  localparam int PIX_W        = 8;
  localparam int PLANE_W      = BLOCK_PIXELS * PIX_W;

  localparam int PIX_R_LSB = 0;
  localparam int PIX_G_LSB = 8;
  localparam int PIX_B_LSB = 16;

  typedef struct packed {
    logic [PIX_W-1:0] b;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] r;
  } rgb_t;

endpackage

// File: rtl/jpeg_block_scheduler_if.sv
// Stream bundle between the scheduler and its host.
//   pix_valid/pix_ready/pix_data : incoming pixel stream (host -> scheduler)
//   out_valid/out_ready/out_data/out_last : result stream (scheduler -> host)
// modport master : host side (drives pixels, accepts results)
// modport slave  : scheduler side
interface jpeg_block_scheduler_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output pix_valid, pix_data, out_ready,
    input  pix_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  pix_valid, pix_data, out_ready,
    output pix_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/block_pack_buffer.sv
// 64-entry x 24-bit pixel store for one 8x8 block.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset (clears storage)
//   i_wr_en        : write strobe for slot i_wr_idx
//   i_wr_idx       : slot 0..63
//   i_wr_pix       : R/G/B bytes of the pixel
//   o_eng_r/g/b    : packed planes, pixel i at [8i+:8]
module block_pack_buffer
  import jpeg_block_scheduler_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  rgb_t               i_wr_pix,
  output logic [PLANE_W-1:0] o_eng_r,
  output logic [PLANE_W-1:0] o_eng_g,
  output logic [PLANE_W-1:0] o_eng_b
);

  rgb_t r_mem [BLOCK_PIXELS];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BLOCK_PIXELS; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_pix;
    end
  end

  for (genvar gi = 0; gi < BLOCK_PIXELS; gi++) begin : g_pack
    assign o_eng_r[gi*PIX_W +: PIX_W] = r_mem[gi].r;
    assign o_eng_g[gi*PIX_W +: PIX_W] = r_mem[gi].g;
    assign o_eng_b[gi*PIX_W +: PIX_W] = r_mem[gi].b;
  end

endmodule

// File: rtl/jpeg_block_scheduler.sv
// Frame scheduler feeding 8x8 RGB blocks to a compression engine.
// Collects 64 pixels, kicks the engine, waits (with timeout) for its result,
// and hands each result word downstream, repeating for cfg_num_blocks blocks.
// Ports:
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_start               : level; rising edge in IDLE launches a frame
//   i_cfg_num_blocks      : blocks per frame, sampled at launch
//   bus                   : pixel and result streams
//   o_eng_start           : one-cycle engine kick
//   o_eng_r/g/b           : packed block planes
//   i_eng_finished        : engine completion pulse, i_eng_fw_data valid with it
//   o_busy, o_done        : status (active block work / frame complete)
//   o_timeout_err         : sticky engine timeout flag
//   o_blocks_done         : results accepted downstream this frame
//   o_state_out           : current state encoding
module jpeg_block_scheduler
  import jpeg_block_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [15:0]          i_cfg_num_blocks,
  jpeg_block_scheduler_if.slave bus,
  output logic                 o_eng_start,
  output logic [PLANE_W-1:0]   o_eng_r,
  output logic [PLANE_W-1:0]   o_eng_g,
  output logic [PLANE_W-1:0]   o_eng_b,
  input  logic                 i_eng_finished,
  input  logic [31:0]          i_eng_fw_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout_err,
  output logic [15:0]          o_blocks_done,
  output logic [3:0]           o_state_out
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_start_d;
  logic [15:0]        r_num_blocks;
  logic [15:0]        r_blocks_done;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_timer;
  logic [31:0]        r_out_data;
  logic               r_timeout_err;

  logic w_start_rise, w_pix_hs, w_out_hs, w_is_last, w_timer_exp;
  logic w_pix_ready, w_eng_start, w_out_valid, w_busy, w_done;
  rgb_t w_pix_rgb;
  logic w_pix_unused;

  assign w_start_rise = i_start & ~r_start_d;
  assign w_pix_hs     = (r_state == ST_FILL) & bus.pix_valid;
  assign w_out_hs     = (r_state == ST_EMIT) & bus.out_ready;
  assign w_is_last    = (r_blocks_done == (r_num_blocks - 16'd1));
  assign w_timer_exp  = (r_timer == 32'(TIMEOUT_CYCLES - 1));

  assign w_pix_rgb    = {bus.pix_data[PIX_B_LSB +: PIX_W],
                         bus.pix_data[PIX_G_LSB +: PIX_W],
                         bus.pix_data[PIX_R_LSB +: PIX_W]};
  // Top byte of the pixel word carries nothing for the engine.
  assign w_pix_unused = ^bus.pix_data[31:24];

  always_comb begin
    w_state_nxt = r_state;
    w_pix_ready = 1'b0;
    w_eng_start = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise)
          w_state_nxt = (i_cfg_num_blocks == 16'd0) ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        w_pix_ready = 1'b1;
        w_busy      = 1'b1;
        if (w_pix_hs && (r_idx == IDX_W'(BLOCK_PIXELS - 1))) w_state_nxt = ST_KICK;
      end
      ST_KICK: begin
        w_eng_start = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        // A completion in the final timer cycle still counts as success.
        if (i_eng_finished)   w_state_nxt = ST_EMIT;
        else if (w_timer_exp) w_state_nxt = ST_IDLE;
      end
      ST_EMIT: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
        if (w_out_hs) w_state_nxt = w_is_last ? ST_DONE : ST_FILL;
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (!i_start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_start_d     <= 1'b0;
      r_num_blocks  <= '0;
      r_blocks_done <= '0;
      r_idx         <= '0;
      r_timer       <= '0;
      r_out_data    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= i_start;
      case (r_state)
        ST_IDLE: begin
          if (w_start_rise) begin
            r_num_blocks  <= i_cfg_num_blocks;
            r_blocks_done <= '0;
            r_timeout_err <= 1'b0;
          end
        end
        // Slot index wraps 63 -> 0 naturally at the block boundary.
        ST_FILL: if (w_pix_hs) r_idx <= r_idx + 1'b1;
        ST_KICK: r_timer <= '0;
        ST_WAIT: begin
          if (i_eng_finished)   r_out_data    <= i_eng_fw_data;
          else if (w_timer_exp) r_timeout_err <= 1'b1;
          else                  r_timer       <= r_timer + 32'd1;
        end
        ST_EMIT: if (w_out_hs) r_blocks_done <= r_blocks_done + 16'd1;
        default: ;
      endcase
    end
  end

  block_pack_buffer u_buf (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr_en  (w_pix_hs),
    .i_wr_idx (r_idx),
    .i_wr_pix (w_pix_rgb),
    .o_eng_r  (o_eng_r),
    .o_eng_g  (o_eng_g),
    .o_eng_b  (o_eng_b)
  );

  assign bus.pix_ready = w_pix_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = w_out_valid & w_is_last;
  assign o_eng_start   = w_eng_start;
  assign o_busy        = w_busy;
  assign o_done        = w_done;
  assign o_timeout_err = r_timeout_err;
  assign o_blocks_done = r_blocks_done;
  assign o_state_out   = r_state;

endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// Self-checking bench for jpeg_block_scheduler with an engine model and a
// result scoreboard.
module tb_jpeg_block_scheduler;
  import jpeg_block_scheduler_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, eng_finished;
  logic [15:0]  cfg;
  logic [31:0]  eng_fw;
  logic         eng_start, busy, done, tmo_err;
  logic [511:0] eng_r, eng_g, eng_b;
  logic [15:0]  blocks_done;
  logic [3:0]   state_out;

  jpeg_block_scheduler_if bus ();

  jpeg_block_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cfg_num_blocks(cfg),
    .bus(bus), .o_eng_start(eng_start), .o_eng_r(eng_r), .o_eng_g(eng_g),
    .o_eng_b(eng_b), .i_eng_finished(eng_finished), .i_eng_fw_data(eng_fw),
    .o_busy(busy), .o_done(done), .o_timeout_err(tmo_err),
    .o_blocks_done(blocks_done), .o_state_out(state_out)
  );

  typedef struct { logic [31:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Engine model control (written by tests) and state (owned by the model).
  int          frame_seq = 0;
  int          spur_cnt  = 0;
  bit          eng_silent = 1'b0;
  logic [31:0] eng_base = '0;
  int          eng_starts = 0;

  initial begin
    int kcount, seq_seen, spur_seen;
    kcount = 0; seq_seen = 0; spur_seen = 0;
    eng_finished = 1'b0; eng_fw = '0;
    forever begin
      @(negedge clk);
      if (seq_seen != frame_seq) begin seq_seen = frame_seq; kcount = 0; end
      if (spur_seen != spur_cnt) begin
        spur_seen = spur_cnt;
        eng_fw = 32'hDEADBEEF; eng_finished = 1'b1;
        @(negedge clk);
        eng_finished = 1'b0; eng_fw = '0;
      end else if (eng_start) begin
        eng_starts++;
        if (!eng_silent) begin
          repeat (9) @(negedge clk);
          eng_fw = eng_base + 32'(kcount); kcount++; eng_finished = 1'b1;
          @(negedge clk);
          eng_finished = 1'b0; eng_fw = '0;
        end
      end
    end
  end

  function automatic logic [511:0] exp_plane(input int b, input int ch);
    logic [511:0] v; int off;
    off = (ch == 0) ? b*7 : (ch == 1) ? 64 + b*5 : 128 + b*3;
    for (int i = 0; i < 64; i++) v[8*i +: 8] = 8'(i + off);
    return v;
  endfunction

  task automatic feed_block(input int b, output bit tmo);
    int cnt;
    tmo = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = {8'hA5, 8'(i + 128 + b*3), 8'(i + 64 + b*5), 8'(i + b*7)};
      cnt = 0;
      while (!bus.pix_ready && cnt < 400) begin @(negedge clk); cnt++; end
      if (!bus.pix_ready) begin tmo = 1'b1; bus.pix_valid = 1'b0; return; end
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int n, input int stall, input logic [31:0] base, input bit glitch);
    int s0;
    exp_t e;
    frame_seq++; eng_base = base; eng_silent = 1'b0; s0 = eng_starts;
    for (int b = 0; b < n; b++) begin
      e.data = base + 32'(b); e.last = (b == n - 1);
      exp_q.push_back(e);
    end
    cfg = 16'(n); start = 1'b1;
    @(negedge clk);
    fork
      begin : feeder
        bit tmo;
        for (int b = 0; b < n; b++) begin
          feed_block(b, tmo);
          n_checks++;
          if (tmo) begin $display("FAIL pix_accept blk%0d: pix_ready low too long", b); n_fail++; break; end
          n_checks++;
          if (eng_start !== 1'b1 || state_out !== 4'(ST_KICK)) begin
            $display("FAIL kick blk%0d: eng_start=%b state=%0d want 1/%0d", b, eng_start, state_out, ST_KICK); n_fail++;
          end
          n_checks++;
          if (eng_r !== exp_plane(b, 0)) begin $display("FAIL pack_r blk%0d: got %h want %h", b, eng_r, exp_plane(b, 0)); n_fail++; end
          n_checks++;
          if (eng_g !== exp_plane(b, 1)) begin $display("FAIL pack_g blk%0d: got %h want %h", b, eng_g, exp_plane(b, 1)); n_fail++; end
          n_checks++;
          if (eng_b !== exp_plane(b, 2)) begin $display("FAIL pack_b blk%0d: got %h want %h", b, eng_b, exp_plane(b, 2)); n_fail++; end
        end
      end
      begin : consumer
        int cnt; logic [31:0] d0; exp_t x;
        for (int b = 0; b < n; b++) begin
          cnt = 0;
          while (!bus.out_valid && cnt < 1000) begin @(negedge clk); cnt++; end
          n_checks++;
          if (!bus.out_valid) begin $display("FAIL out_valid blk%0d: never asserted", b); n_fail++; break; end
          d0 = bus.out_data;
          for (int s = 0; s < stall; s++) begin
            n_checks++;
            if (bus.pix_ready !== 1'b0 || bus.out_data !== d0 || bus.out_valid !== 1'b1) begin
              $display("FAIL emit_hold blk%0d cyc%0d: pix_ready=%b out_valid=%b data=%h want 0/1/%h",
                       b, s, bus.pix_ready, bus.out_valid, bus.out_data, d0); n_fail++;
            end
            @(negedge clk);
          end
          n_checks++;
          if (exp_q.size() == 0) begin $display("FAIL scoreboard blk%0d: unexpected result %h", b, bus.out_data); n_fail++; end
          else begin
            x = exp_q.pop_front();
            if (bus.out_data !== x.data || bus.out_last !== x.last) begin
              $display("FAIL result blk%0d: data=%h last=%b want %h/%b", b, bus.out_data, bus.out_last, x.data, x.last); n_fail++;
            end
          end
          bus.out_ready = 1'b1;
          @(negedge clk);
          bus.out_ready = 1'b0;
          n_checks++;
          if (blocks_done !== 16'(b + 1)) begin $display("FAIL blocks_done blk%0d: got %0d want %0d", b, blocks_done, b + 1); n_fail++; end
        end
      end
      begin : glitcher
        int cnt; logic [31:0] d1;
        if (glitch) begin
          repeat (10) @(negedge clk);
          d1 = bus.out_data;
          spur_cnt++;
          repeat (4) @(negedge clk);
          n_checks++;
          if (bus.out_data !== d1 || state_out !== 4'(ST_FILL)) begin
            $display("FAIL spurious_finish: data=%h state=%0d want %h/%0d", bus.out_data, state_out, d1, ST_FILL); n_fail++;
          end
          cnt = 0;
          while (state_out !== 4'(ST_WAIT) && cnt < 300) begin @(negedge clk); cnt++; end
          start = 1'b0; @(negedge clk);
          start = 1'b1; @(negedge clk);
          n_checks++;
          if (state_out !== 4'(ST_WAIT) || busy !== 1'b1) begin
            $display("FAIL start_in_wait: state=%0d busy=%b want %0d/1", state_out, busy, ST_WAIT); n_fail++;
          end
        end
      end
    join
    n_checks++;
    if (eng_starts - s0 != n) begin $display("FAIL eng_start_count: got %0d want %0d", eng_starts - s0, n); n_fail++; end
    n_checks++;
    if (exp_q.size() != 0) begin $display("FAIL scoreboard_left: %0d results missing", exp_q.size()); n_fail++; exp_q.delete(); end
    n_checks++;
    if (state_out !== 4'(ST_DONE) || done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || blocks_done !== 16'(n)) begin
      $display("FAIL frame_done: state=%0d done=%b busy=%b out_valid=%b blocks=%0d want %0d/1/0/0/%0d",
               state_out, done, busy, bus.out_valid, blocks_done, ST_DONE, n); n_fail++;
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_out !== 4'(ST_IDLE) || done !== 1'b0) begin
      $display("FAIL done_to_idle: state=%0d done=%b want %0d/0", state_out, done, ST_IDLE); n_fail++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cfg = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_out !== 4'(ST_IDLE) || bus.pix_ready !== 1'b0 || eng_start !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tmo_err !== 1'b0) begin
      $display("FAIL reset_ctrl: state=%0d pr=%b es=%b ov=%b ol=%b busy=%b done=%b te=%b want all 0",
               state_out, bus.pix_ready, eng_start, bus.out_valid, bus.out_last, busy, done, tmo_err); n_fail++;
    end
    n_checks++;
    if (bus.out_data !== 32'd0 || blocks_done !== 16'd0 || eng_r !== '0 || eng_g !== '0 || eng_b !== '0) begin
      $display("FAIL reset_data: out_data=%h blocks=%0d planes nonzero=%b want 0", bus.out_data, blocks_done,
               (eng_r != '0) || (eng_g != '0) || (eng_b != '0)); n_fail++;
    end
  endtask

  task automatic test_single_block();
    run_frame(1, 0, 32'hCAFE0001, 1'b0);
    n_checks++;
    if (bus.out_data !== 32'hCAFE0001) begin $display("FAIL single_out_data: got %h want cafe0001", bus.out_data); n_fail++; end
  endtask

  task automatic test_multi_stall();
    run_frame(3, 20, 32'h10000000, 1'b0);
  endtask

  task automatic test_timeout();
    bit tmo, seen_valid; int w;
    frame_seq++; eng_silent = 1'b1; cfg = 16'd1; start = 1'b1;
    @(negedge clk);
    feed_block(0, tmo);
    n_checks++;
    if (tmo || state_out !== 4'(ST_KICK)) begin $display("FAIL tmo_fill: tmo=%b state=%0d want 0/%0d", tmo, state_out, ST_KICK); n_fail++; end
    seen_valid = 1'b0; w = 0;
    @(negedge clk);
    while (state_out === 4'(ST_WAIT) && w < 100) begin
      if (bus.out_valid) seen_valid = 1'b1;
      w++; @(negedge clk);
    end
    n_checks++;
    if (w != TMO) begin $display("FAIL tmo_wait_len: got %0d want %0d", w, TMO); n_fail++; end
    n_checks++;
    if (state_out !== 4'(ST_IDLE) || tmo_err !== 1'b1 || busy !== 1'b0 || seen_valid || bus.out_valid !== 1'b0) begin
      $display("FAIL tmo_end: state=%0d err=%b busy=%b valid_seen=%b want %0d/1/0/0", state_out, tmo_err, busy, seen_valid, ST_IDLE); n_fail++;
    end
    start = 1'b0; eng_silent = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tmo_err !== 1'b1) begin $display("FAIL tmo_sticky: got %b want 1", tmo_err); n_fail++; end
  endtask

  task automatic test_zero_blocks();
    int s0;
    s0 = eng_starts;
    cfg = 16'd0; start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_out !== 4'(ST_DONE) || done !== 1'b1 || busy !== 1'b0 || tmo_err !== 1'b0) begin
      $display("FAIL zero_done: state=%0d done=%b busy=%b err=%b want %0d/1/0/0", state_out, done, busy, tmo_err, ST_DONE); n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.pix_ready !== 1'b0 || eng_start !== 1'b0 || state_out !== 4'(ST_DONE)) begin
        $display("FAIL zero_hold cyc%0d: pr=%b es=%b state=%0d want 0/0/%0d", i, bus.pix_ready, eng_start, state_out, ST_DONE); n_fail++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (eng_starts != s0) begin $display("FAIL zero_kicks: got %0d want 0", eng_starts - s0); n_fail++; end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_out !== 4'(ST_IDLE)) begin $display("FAIL zero_idle: state=%0d want %0d", state_out, ST_IDLE); n_fail++; end
  endtask

  task automatic test_reset_mid_fill();
    frame_seq++; cfg = 16'd1; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      bus.pix_valid = 1'b1; bus.pix_data = 32'hFFFFFFFF;
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
    n_checks++;
    if (dut.r_idx !== 6'd30) begin $display("FAIL midfill_idx: got %0d want 30", dut.r_idx); n_fail++; end
    rst_n = 1'b0; start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (state_out !== 4'(ST_IDLE) || dut.r_idx !== 6'd0 || bus.out_valid !== 1'b0 || eng_r !== '0) begin
      $display("FAIL midfill_reset: state=%0d idx=%0d ov=%b want %0d/0/0", state_out, dut.r_idx, bus.out_valid, ST_IDLE); n_fail++;
    end
    @(negedge clk);
    run_frame(1, 0, 32'h5A5A0000, 1'b0);
  endtask

  task automatic test_spurious();
    run_frame(1, 3, 32'h77770000, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_multi_stall();
    test_timeout();
    test_zero_blocks();
    test_reset_mid_fill();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
